// File: rtl/serial_byte_assembler_pkg.sv
// Shared definitions for the serial byte assembler: FSM encoding and framing bit levels.
package serial_byte_assembler_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_byte_assembler_parity_accumulator.sv
// Running XOR of the data bits of the current frame.
module parity_accumulator (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic bit_in,
  output logic parity
);

  logic parity_reg;

  // Cleared by the start bit so every frame begins from zero; folds in each data bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_reg <= 1'b0;
    end else if (clear) begin
      parity_reg <= 1'b0;
    end else if (enable) begin
      parity_reg <= parity_reg ^ bit_in;
    end
  end

  assign parity = parity_reg;

endmodule

// File: rtl/serial_byte_assembler.sv
// Deframes a strobed serial stream (start, LSB-first data, optional parity, stop)
// into a byte and presents it with a one-cycle load pulse.
module serial_byte_assembler
  import serial_byte_assembler_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ser_in,
  input  logic                  ser_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  load,
  output logic                  busy,
  output logic                  parity_err,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0]   data_reg, data_next;
  logic                    load_reg, load_next;
  logic                    perr_reg, perr_next;
  logic                    ferr_reg, ferr_next;
  logic                    busy_reg, busy_next;
  logic                    par_fail_reg, par_fail_next;

  logic                    acc_clear;
  logic                    acc_en;
  logic                    acc_parity;

  assign acc_clear = ser_valid && (state_reg == IDLE) && (ser_in == START_BIT);
  assign acc_en    = ser_valid && (state_reg == DATA);

  parity_accumulator u_parity (
    .clk    (CLK),
    .rst    (RST),
    .clear  (acc_clear),
    .enable (acc_en),
    .bit_in (ser_in),
    .parity (acc_parity)
  );

  // State and datapath registers; a reset mid-frame simply drops the partial byte.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      cnt_reg      <= '0;
      data_reg     <= '0;
      load_reg     <= 1'b0;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      par_fail_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      cnt_reg      <= cnt_next;
      data_reg     <= data_next;
      load_reg     <= load_next;
      perr_reg     <= perr_next;
      ferr_reg     <= ferr_next;
      busy_reg     <= busy_next;
      par_fail_reg <= par_fail_next;
    end
  end

  // Next-state and pulse generation; nothing advances without a strobe.
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    cnt_next      = cnt_reg;
    data_next     = data_reg;
    load_next     = 1'b0;
    perr_next     = 1'b0;
    ferr_next     = 1'b0;
    par_fail_next = par_fail_reg;

    if (ser_valid) begin
      unique case (state_reg)
        IDLE: begin
          // A 1 on an idle line is just the line resting high.
          if (ser_in == START_BIT) begin
            state_next    = DATA;
            cnt_next      = '0;
            par_fail_next = 1'b0;
          end
        end
        DATA: begin
          // LSB first: shifting in from the top leaves the first bit in bit 0.
          shift_next = {ser_in, shift_reg[DATA_WIDTH-1:1]};
          cnt_next   = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(DATA_WIDTH - 1)) begin
            state_next = PARITY_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          par_fail_next = ((acc_parity ^ ser_in) != PARITY_ODD);
          state_next    = STOP;
        end
        STOP: begin
          // A bad stop bit outranks a parity failure; it is never reused as a start bit.
          state_next = IDLE;
          if (ser_in != STOP_BIT) begin
            ferr_next = 1'b1;
          end else if (par_fail_reg) begin
            perr_next = 1'b1;
          end else begin
            load_next = 1'b1;
            data_next = shift_reg;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    busy_next = (state_next != IDLE);
  end

  assign data_out   = data_reg;
  assign load       = load_reg;
  assign busy       = busy_reg;
  assign parity_err = perr_reg;
  assign frame_err  = ferr_reg;

endmodule

// File: tb/tb_serial_byte_assembler.sv
// Bench: two assemblers (with and without parity) against a frame-level model.
module tb_serial_byte_assembler;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [1:0] ser_in = 2'b11;
  logic [1:0] ser_valid = 2'b00;
  logic [7:0] dout [2];
  logic [1:0] load, busy, perr, ferr;

  logic [7:0] exp_data [2];
  logic [1:0] exp_load, exp_busy, exp_perr, exp_ferr;

  int   total_cnt = 0;
  int   pass_cnt  = 0;
  int   n_load [2] = '{0, 0};
  int   n_perr [2] = '{0, 0};
  int   n_ferr [2] = '{0, 0};
  bit   cmp_en = 1'b0;

  always #5 CLK = ~CLK;

  serial_byte_assembler #(.DATA_WIDTH(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
    .CLK(CLK), .RST(RST), .ser_in(ser_in[0]), .ser_valid(ser_valid[0]),
    .data_out(dout[0]), .load(load[0]), .busy(busy[0]),
    .parity_err(perr[0]), .frame_err(ferr[0])
  );

  serial_byte_assembler #(.DATA_WIDTH(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_np (
    .CLK(CLK), .RST(RST), .ser_in(ser_in[1]), .ser_valid(ser_valid[1]),
    .data_out(dout[1]), .load(load[1]), .busy(busy[1]),
    .parity_err(perr[1]), .frame_err(ferr[1])
  );

  // Judge a complete frame (bits after the start bit, LSB first): {load, perr, ferr, data}.
  function automatic logic [10:0] judge(input logic [15:0] bits, input bit pen);
    logic [7:0] d;
    logic       stop;
    int         ones;
    logic       bad_par;
    d       = bits[7:0];
    stop    = pen ? bits[9] : bits[8];
    ones    = $countones(d) + ((pen && bits[8]) ? 1 : 0);
    bad_par = pen && ((ones % 2) != 0);
    return {stop && !bad_par, stop && bad_par, !stop, d};
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_model
    localparam bit PEN = (gi == 0);
    localparam int FL  = PEN ? 10 : 9;
    int          m_len = -1;
    logic [15:0] m_bits = '0;
    logic        q_load = 1'b0, q_perr = 1'b0, q_ferr = 1'b0;
    logic [7:0]  q_data = '0;
    logic [10:0] verdict;

    assign verdict = judge(m_bits | (16'(ser_in[gi]) << m_len), PEN);

    always @(posedge CLK or posedge RST) begin
      if (RST) begin
        m_len  <= -1;
        m_bits <= '0;
        q_load <= 1'b0;
        q_perr <= 1'b0;
        q_ferr <= 1'b0;
        q_data <= '0;
      end else begin
        q_load <= 1'b0;
        q_perr <= 1'b0;
        q_ferr <= 1'b0;
        if (ser_valid[gi]) begin
          if (m_len < 0) begin
            if (ser_in[gi] == 1'b0) begin
              m_len  <= 0;
              m_bits <= '0;
            end
          end else if (m_len == FL - 1) begin
            q_load <= verdict[10];
            q_perr <= verdict[9];
            q_ferr <= verdict[8];
            if (verdict[10]) q_data <= verdict[7:0];
            m_len  <= -1;
          end else begin
            m_bits <= m_bits | (16'(ser_in[gi]) << m_len);
            m_len  <= m_len + 1;
          end
        end
      end
    end

    assign exp_load[gi] = q_load;
    assign exp_perr[gi] = q_perr;
    assign exp_ferr[gi] = q_ferr;
    assign exp_busy[gi] = (m_len >= 0);
    assign exp_data[gi] = q_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Cycle-by-cycle comparison of both DUTs against the model, plus pulse counting.
  always @(negedge CLK) begin
    if (cmp_en) begin
      for (int ch = 0; ch < 2; ch++) begin
        check($sformatf("ch%0d load", ch), 32'(load[ch]), 32'(exp_load[ch]));
        check($sformatf("ch%0d parity_err", ch), 32'(perr[ch]), 32'(exp_perr[ch]));
        check($sformatf("ch%0d frame_err", ch), 32'(ferr[ch]), 32'(exp_ferr[ch]));
        check($sformatf("ch%0d busy", ch), 32'(busy[ch]), 32'(exp_busy[ch]));
        check($sformatf("ch%0d data_out", ch), 32'(dout[ch]), 32'(exp_data[ch]));
        if (load[ch]) n_load[ch]++;
        if (perr[ch]) n_perr[ch]++;
        if (ferr[ch]) n_ferr[ch]++;
      end
    end
  end

  // Called at a falling edge; holds the strobe for one cycle, then idles gap cycles.
  task automatic send_bit(input int ch, input logic b, input int gap);
    ser_in[ch]    = b;
    ser_valid[ch] = 1'b1;
    @(negedge CLK);
    ser_valid[ch] = 1'b0;
    ser_in[ch]    = 1'b1;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic send_frame(input int ch, input logic [7:0] b, input bit flip,
                            input logic stop, input int gap);
    send_bit(ch, 1'b0, gap);
    for (int i = 0; i < 8; i++) send_bit(ch, b[i], gap);
    if (ch == 0) send_bit(ch, (^b) ^ flip, gap);
    send_bit(ch, stop, gap);
    $display("frame ch%0d byte=0x%02h parity_flip=%0d stop=%0d gap=%0d", ch, b, flip, stop, gap);
  endtask

  int l0, p0, f0;

  initial begin
    #1 RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check("reset data_out", 32'(dout[0]), 32'h0);
    check("reset busy", 32'(busy[0]), 32'h0);
    check("reset load", 32'(load[0]), 32'h0);
    cmp_en = 1'b1;

    // Reset mid-frame after four data bits.
    send_bit(0, 1'b0, 0);
    send_bit(0, 1'b1, 0);
    send_bit(0, 1'b0, 0);
    send_bit(0, 1'b1, 0);
    send_bit(0, 1'b1, 0);
    check("busy mid-frame", 32'(busy[0]), 32'h1);
    #2 RST = 1'b1;
    #1;
    check("async rst busy", 32'(busy[0]), 32'h0);
    check("async rst data_out", 32'(dout[0]), 32'h0);
    check("async rst outputs", 32'({load[0], perr[0], ferr[0]}), 32'h0);
    $display("reset asserted mid-frame");
    @(negedge CLK);
    RST = 1'b0;

    l0 = n_load[0];
    send_frame(0, 8'h3C, 1'b0, 1'b1, 0);
    repeat (3) @(negedge CLK);
    check("0x3C data_out", 32'(dout[0]), 32'h3C);
    check("0x3C load count", 32'(n_load[0] - l0), 32'd1);

    // Good frame 0xA5, even parity bit 0.
    l0 = n_load[0];
    send_frame(0, 8'hA5, 1'b0, 1'b1, 0);
    repeat (3) @(negedge CLK);
    check("0xA5 data_out", 32'(dout[0]), 32'hA5);
    check("model 0xA5", 32'(exp_data[0]), 32'hA5);
    check("0xA5 load count", 32'(n_load[0] - l0), 32'd1);
    check("0xA5 busy idle", 32'(busy[0]), 32'h0);

    // Parity error: same byte with the parity bit inverted.
    l0 = n_load[0]; p0 = n_perr[0];
    send_frame(0, 8'hA5, 1'b1, 1'b1, 0);
    repeat (3) @(negedge CLK);
    check("perr count", 32'(n_perr[0] - p0), 32'd1);
    check("perr load count", 32'(n_load[0] - l0), 32'd0);
    check("perr data_out kept", 32'(dout[0]), 32'hA5);

    // Frame error, then an immediate 1 strobe must not start a frame.
    l0 = n_load[0]; f0 = n_ferr[0]; p0 = n_perr[0];
    send_frame(0, 8'h0F, 1'b0, 1'b0, 0);
    send_bit(0, 1'b1, 0);
    check("idle after 1 strobe", 32'(busy[0]), 32'h0);
    repeat (2) @(negedge CLK);
    check("ferr count", 32'(n_ferr[0] - f0), 32'd1);
    check("ferr perr count", 32'(n_perr[0] - p0), 32'd0);
    check("ferr load count", 32'(n_load[0] - l0), 32'd0);
    check("ferr data_out kept", 32'(dout[0]), 32'hA5);
    send_frame(0, 8'h81, 1'b0, 1'b1, 0);
    repeat (2) @(negedge CLK);
    check("after ferr data_out", 32'(dout[0]), 32'h81);

    // Back-to-back frames, strobe every third cycle.
    l0 = n_load[0]; p0 = n_perr[0]; f0 = n_ferr[0];
    send_frame(0, 8'h01, 1'b0, 1'b1, 2);
    check("b2b first data_out", 32'(dout[0]), 32'h01);
    check("model b2b first", 32'(exp_data[0]), 32'h01);
    send_frame(0, 8'hFF, 1'b0, 1'b1, 2);
    repeat (2) @(negedge CLK);
    check("b2b second data_out", 32'(dout[0]), 32'hFF);
    check("b2b load count", 32'(n_load[0] - l0), 32'd2);
    check("b2b error count", 32'((n_perr[0] - p0) + (n_ferr[0] - f0)), 32'd0);

    // No-parity build: 10 strobes per frame.
    l0 = n_load[1];
    send_frame(1, 8'h80, 1'b0, 1'b1, 0);
    repeat (2) @(negedge CLK);
    check("nopar data_out", 32'(dout[1]), 32'h80);
    check("model nopar", 32'(exp_data[1]), 32'h80);
    check("nopar load count", 32'(n_load[1] - l0), 32'd1);

    repeat (2) @(negedge CLK);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
